vector_mem_stage: RTL and testbench

Memory-access stage between Execute and writeback in the vector CPU pipeline. It captures the Execute result (`out`: 64-bit vector or zero-extended 19-bit scalar), the store data (`dataToWrite`) and the NZVC flags. It performs scalar or 8×8-bit vector loads/stores over a 32-bit data-memory port with a req/ack handshake, sequencing vectors as two word beats. It presents one registered retire record per instruction to writeback and stalls Execute while a memory access is in flight.

---
 rtl/vector_mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_vector_mem_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_stage.sv
// Memory-access stage: captures the Execute result, runs scalar or two-beat vector
// loads/stores over a 32-bit req/ack port, and emits one registered retire record per instruction.
module vector_mem_stage #(
    parameter int DATA_WIDTH  = 19,
    parameter int WIDTH       = 8,
    parameter int VECTOR_SIZE = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int REG_ADDR    = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH*VECTOR_SIZE-1:0]    in_result,
    input  logic [WIDTH*VECTOR_SIZE-1:0]    in_store_data,
    input  logic                            in_mem_read,
    input  logic                            in_mem_write,
    input  logic                            in_is_vector,
    input  logic                            in_reg_write,
    input  logic [REG_ADDR-1:0]             in_dest,
    input  logic [3:0]                      in_flags,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [31:0]                     mem_wdata,
    input  logic [31:0]                     mem_rdata,
    input  logic                            mem_ack,
    output logic                            wb_valid,
    output logic [WIDTH*VECTOR_SIZE-1:0]    wb_data,
    output logic                            wb_reg_write,
    output logic                            wb_is_vector,
    output logic [REG_ADDR-1:0]             wb_dest,
    output logic [3:0]                      wb_flags
);

    localparam int VecBits = WIDTH * VECTOR_SIZE;
    localparam int Half    = VecBits / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } stateT;

    stateT state, stateNext;

    logic [VecBits-1:0]    capResult;
    logic [VecBits-1:0]    capStore;
    logic [ADDR_WIDTH-1:0] capAddr;
    logic                  capWrite;
    logic                  capVector;
    logic                  capRegWrite;
    logic [REG_ADDR-1:0]   capDest;
    logic [3:0]            capFlags;
    logic [Half-1:0]       lowBeat;

    logic                  accept;
    logic                  memOpIn;
    logic                  retireNow;
    logic [VecBits-1:0]    retireData;
    logic                  retireRegWrite;
    logic                  retireVector;
    logic [REG_ADDR-1:0]   retireDest;
    logic [3:0]            retireFlags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        in_ready  = (state == IDLE);
        accept    = in_valid && (state == IDLE);
        memOpIn   = in_mem_read || in_mem_write;
        unique case (state)
            IDLE:    if (accept && memOpIn) stateNext = BEAT0;
            BEAT0:   if (mem_ack) stateNext = capVector ? BEAT1 : IDLE;
            BEAT1:   if (mem_ack) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Non-mem instructions retire straight from the inputs; mem ops retire from captured state.
    always_comb begin
        retireNow      = 1'b0;
        retireData     = capResult;
        retireRegWrite = capRegWrite && !capWrite;
        retireVector   = capVector;
        retireDest     = capDest;
        retireFlags    = capFlags;
        unique case (state)
            IDLE: begin
                if (accept && !memOpIn) begin
                    retireNow      = 1'b1;
                    retireData     = in_result;
                    retireRegWrite = in_reg_write;
                    retireVector   = in_is_vector;
                    retireDest     = in_dest;
                    retireFlags    = in_flags;
                end
            end
            BEAT0: begin
                if (mem_ack && !capVector) begin
                    retireNow = 1'b1;
                    if (!capWrite)
                        retireData = {{(VecBits-DATA_WIDTH){1'b0}}, mem_rdata[DATA_WIDTH-1:0]};
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    retireNow = 1'b1;
                    if (!capWrite) retireData = {mem_rdata, lowBeat};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capResult    <= '0;
            capStore     <= '0;
            capAddr      <= '0;
            capWrite     <= 1'b0;
            capVector    <= 1'b0;
            capRegWrite  <= 1'b0;
            capDest      <= '0;
            capFlags     <= '0;
            lowBeat      <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        capResult   <= in_result;
                        capStore    <= in_store_data;
                        capAddr     <= in_result[ADDR_WIDTH-1:0];
                        capWrite    <= in_mem_write;
                        capVector   <= in_is_vector;
                        capRegWrite <= in_reg_write;
                        capDest     <= in_dest;
                        capFlags    <= in_flags;
                        if (memOpIn) begin
                            mem_req   <= 1'b1;
                            mem_we    <= in_mem_write;
                            mem_addr  <= in_result[ADDR_WIDTH-1:0];
                            mem_wdata <= in_is_vector ? in_store_data[Half-1:0]
                                       : {{(Half-DATA_WIDTH){1'b0}}, in_store_data[DATA_WIDTH-1:0]};
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
                        if (capVector) begin
                            lowBeat   <= mem_rdata;
                            mem_addr  <= capAddr + 1'b1;
                            mem_wdata <= capStore[VecBits-1:Half];
                        end else begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            wb_is_vector <= 1'b0;
            wb_dest      <= '0;
            wb_flags     <= '0;
        end else begin
            wb_valid <= retireNow;
            if (retireNow) begin
                wb_data      <= retireData;
                wb_reg_write <= retireRegWrite;
                wb_is_vector <= retireVector;
                wb_dest      <= retireDest;
                wb_flags     <= retireFlags;
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_stage.sv
// Directed bench for vector_mem_stage: hand-computed expectations checked with immediate assertions.
module tb_vector_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [63:0] in_store_data;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_is_vector;
    logic        in_reg_write;
    logic [4:0]  in_dest;
    logic [3:0]  in_flags;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic        wb_reg_write;
    logic        wb_is_vector;
    logic [4:0]  wb_dest;
    logic [3:0]  wb_flags;

    int errors = 0;
    int checks = 0;

    vector_mem_stage #(
        .DATA_WIDTH(19), .WIDTH(8), .VECTOR_SIZE(8), .ADDR_WIDTH(10), .REG_ADDR(5)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_store_data(in_store_data),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_is_vector(in_is_vector), .in_reg_write(in_reg_write),
        .in_dest(in_dest), .in_flags(in_flags),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
        .wb_is_vector(wb_is_vector), .wb_dest(wb_dest), .wb_flags(wb_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_is_vector = 0;
        in_reg_write = 0; in_dest = '0; in_flags = '0; in_result = '0; in_store_data = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    initial begin
        idleInputs();
        reset = 1;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        tick();
        reset = 0;
        tick();

        // Reset in the middle of a vector load
        in_valid = 1; in_mem_read = 1; in_is_vector = 1; in_reg_write = 1; in_result = 64'h20;
        tick();
        idleInputs();
        chk("v_abort_beat0_req", mem_req, 1);
        chk("v_abort_beat0_ready", in_ready, 0);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 0;
        chk("v_abort_beat1_addr", mem_addr, 10'h021);
        #2 reset = 1;
        #1;
        chk("abort_req_async", mem_req, 0);
        chk("abort_addr_async", mem_addr, 0);
        chk("abort_ready_async", in_ready, 1);
        chk("abort_wb_valid", wb_valid, 0);
        tick();
        reset = 0;
        tick();
        chk("abort_no_retire", wb_valid, 0);
        in_valid = 1; in_result = 64'h4; in_reg_write = 1; in_dest = 5'd3;
        tick();
        idleInputs();
        chk("post_rst_valid", wb_valid, 1);
        chk("post_rst_data", wb_data, 64'h4);
        chk("post_rst_dest", wb_dest, 5'd3);
        chk("post_rst_regw", wb_reg_write, 1);
        tick();
        chk("post_rst_pulse", wb_valid, 0);

        // Back-to-back non-mem accepts
        in_valid = 1; in_reg_write = 1; in_result = 64'h4;
        tick();
        chk("nm0_valid", wb_valid, 1);
        chk("nm0_data", wb_data, 64'h4);
        chk("nm0_ready", in_ready, 1);
        in_result = 64'h2; in_flags = 4'b0100;
        tick();
        chk("nm1_valid", wb_valid, 1);
        chk("nm1_data", wb_data, 64'h2);
        chk("nm1_flags", wb_flags, 4'b0100);
        in_result = 64'h3; in_flags = 4'b0000;
        tick();
        idleInputs();
        chk("nm2_valid", wb_valid, 1);
        chk("nm2_data", wb_data, 64'h3);
        chk("nm2_flags", wb_flags, 4'b0000);
        tick();
        chk("nm_end_valid", wb_valid, 0);
        chk("nm_hold_data", wb_data, 64'h3);

        // Stray ack while idle is ignored
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("idle_ack_valid", wb_valid, 0);
        chk("idle_ack_req", mem_req, 0);

        // Scalar load with two wait cycles
        in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_result = 64'h5; in_dest = 5'd7;
        tick();
        idleInputs();
        chk("sl_req", mem_req, 1);
        chk("sl_addr", mem_addr, 10'h005);
        chk("sl_we", mem_we, 0);
        chk("sl_ready", in_ready, 0);
        tick();
        chk("sl_wait_req", mem_req, 1);
        chk("sl_wait_valid", wb_valid, 0);
        tick();
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        idleInputs();
        chk("sl_valid", wb_valid, 1);
        chk("sl_data", wb_data, 64'h7FFFF);
        chk("sl_regw", wb_reg_write, 1);
        chk("sl_dest", wb_dest, 5'd7);
        chk("sl_req_drop", mem_req, 0);
        chk("sl_ready_back", in_ready, 1);

        // Vector load wrapping the address
        in_valid = 1; in_mem_read = 1; in_is_vector = 1; in_reg_write = 1;
        in_result = 64'h3FF; in_dest = 5'd9;
        tick();
        idleInputs();
        chk("vl_addr0", mem_addr, 10'h3FF);
        chk("vl_req0", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'h0502_0403;
        tick();
        chk("vl_addr1", mem_addr, 10'h000);
        chk("vl_req1", mem_req, 1);
        chk("vl_mid_valid", wb_valid, 0);
        mem_rdata = 32'h0500_0503;
        tick();
        idleInputs();
        chk("vl_valid", wb_valid, 1);
        chk("vl_data", wb_data, 64'h0500_0503_0502_0403);
        chk("vl_isvec", wb_is_vector, 1);
        chk("vl_req_drop", mem_req, 0);

        // Vector store
        in_valid = 1; in_mem_write = 1; in_is_vector = 1; in_reg_write = 1;
        in_result = 64'h10; in_store_data = 64'h0A04_0A06_0A04_0802;
        tick();
        idleInputs();
        chk("vs_we0", mem_we, 1);
        chk("vs_addr0", mem_addr, 10'h010);
        chk("vs_wdata0", mem_wdata, 32'h0A04_0802);
        mem_ack = 1;
        tick();
        chk("vs_we1", mem_we, 1);
        chk("vs_addr1", mem_addr, 10'h011);
        chk("vs_wdata1", mem_wdata, 32'h0A04_0A06);
        tick();
        idleInputs();
        chk("vs_valid", wb_valid, 1);
        chk("vs_regw", wb_reg_write, 0);
        chk("vs_data", wb_data, 64'h10);

        // Read and write both set: performed as a scalar write
        in_valid = 1; in_mem_read = 1; in_mem_write = 1; in_reg_write = 1;
        in_result = 64'h22; in_store_data = 64'hFFFF_FFFF_FFF8_1234; in_flags = 4'b1011;
        tick();
        idleInputs();
        chk("rw_we", mem_we, 1);
        chk("rw_addr", mem_addr, 10'h022);
        chk("rw_wdata", mem_wdata, 32'h0000_1234);
        mem_ack = 1;
        tick();
        idleInputs();
        chk("rw_valid", wb_valid, 1);
        chk("rw_regw", wb_reg_write, 0);
        chk("rw_data", wb_data, 64'h22);
        chk("rw_flags", wb_flags, 4'b1011);
        chk("rw_isvec", wb_is_vector, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
